load_receiver: RTL and testbench

Processor-side deserializer and run controller for the FPGA demo loader. It samples the serial `mosi` stream and the 2-bit `mode` from the upstream driver, and reassembles 13-bit frames of the form {pad, byte, addr}. Each completed frame becomes a single-cycle write into instruction memory or the register file. The block also gates core execution during run mode and returns `done` to the driver when the core halts.

---
 rtl/loader_pkg.sv | 26 ++
 rtl/frame_deser.sv | 41 ++++
 rtl/load_receiver.sv | 154 +++++++++++++++
 tb/tb_load_receiver.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and frame-layout constants for the demo loader receiver.
package loader_pkg;

  // Frame layout: {pad, byte, addr}, shifted in LSB first.
  localparam int FRAME_W  = 13;
  localparam int ADDR_LSB = 0;
  localparam int DATA_LSB = 4;
  localparam int PAD_BIT  = 12;

  // Command codes driven by the upstream loader.
  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_LD_I = 2'b01,
    MODE_LD_D = 2'b10,
    MODE_RUN  = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_I,
    ST_SHIFT_D,
    ST_RUN,
    ST_DONE
  } ld_state_t;

endpackage

// File: rtl/frame_deser.sv
// Serial-to-parallel capture register with a saturating sample counter.
// The register always holds the most recent FRAME_W samples, oldest at bit 0.
module frame_deser #(
  parameter int FRAME_W = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic               bit_in,
  output logic [FRAME_W-1:0] frame,
  output logic               full
);

  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_W);

  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_base;

  // A clear in the same cycle as a sample restarts the count at that sample.
  always_comb cnt_base = clr ? '0 : bit_cnt;

  // Shift in one sample per enabled cycle; the count sticks at a full frame.
  always_ff @(posedge clk) begin
    // NOTE: the shift register is a handful of flops, not a RAM, so it is
    // reset along with the control state and never exposes stale samples.
    if (rst) begin
      frame   <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      frame   <= {bit_in, frame[FRAME_W-1:1]};
      bit_cnt <= (cnt_base != CNT_MAX) ? cnt_base + CNT_W'(1) : cnt_base;
    end else if (clr) begin
      bit_cnt <= '0;
    end
  end

  assign full = (bit_cnt == CNT_MAX);

endmodule

// File: rtl/load_receiver.sv
// Loader receiver: deserializes {pad, byte, addr} frames into one-cycle
// instruction/register-file writes and gates core execution in run mode.
// Optional build macro LOADER_FRAME_CHECK_EN: rejects frames whose pad bit
// is 1 and flags halt_in asserted while not running.
module load_receiver
  import loader_pkg::*;
#(
  parameter int FRAME_W = loader_pkg::FRAME_W,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mosi_in,
  input  logic [1:0]        mode_in,
  input  logic              halt_in,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              run_en,
  output logic              done_out,
  output logic              err_out
);

  ld_state_t          state, state_next;
  mode_t              mode, load_code;
  logic [FRAME_W-1:0] frame;
  logic               full;
  logic               frame_ok;
  logic               deser_clr, deser_en;
  logic               commit, imem_we_next, dmem_we_next, err_set;

  assign mode = mode_t'(mode_in);

  frame_deser #(
    .FRAME_W (FRAME_W)
  ) u_deser (
    .clk    (clk),
    .rst    (rst),
    .clr    (deser_clr),
    .en     (deser_en),
    .bit_in (mosi_in),
    .frame  (frame),
    .full   (full)
  );

`ifdef LOADER_FRAME_CHECK_EN
  assign frame_ok = ~frame[PAD_BIT];
`else
  logic unused_pad;
  assign unused_pad = frame[PAD_BIT];
  assign frame_ok   = 1'b1;
`endif

  // Next-state, sampling control and write/error decisions.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_next   = state;
    load_code    = MODE_LD_I;
    deser_clr    = 1'b0;
    deser_en     = 1'b0;
    commit       = 1'b0;
    imem_we_next = 1'b0;
    dmem_we_next = 1'b0;
    err_set      = 1'b0;

    case (state)
      ST_IDLE: begin
        // The detection cycle is also the first sample of the frame.
        case (mode)
          MODE_LD_I: begin
            state_next = ST_SHIFT_I;
            deser_clr  = 1'b1;
            deser_en   = 1'b1;
          end
          MODE_LD_D: begin
            state_next = ST_SHIFT_D;
            deser_clr  = 1'b1;
            deser_en   = 1'b1;
          end
          MODE_RUN: state_next = ST_RUN;
          default:  state_next = ST_IDLE;
        endcase
`ifdef LOADER_FRAME_CHECK_EN
        if (halt_in) err_set = 1'b1;
`endif
      end

      ST_SHIFT_I, ST_SHIFT_D: begin
        load_code = (state == ST_SHIFT_I) ? MODE_LD_I : MODE_LD_D;
        if (mode == load_code) begin
          deser_en = 1'b1;
        end else if (mode == MODE_IDLE) begin
          state_next = ST_IDLE;
          if (full && frame_ok) begin
            commit       = 1'b1;
            imem_we_next = (state == ST_SHIFT_I);
            dmem_we_next = (state == ST_SHIFT_D);
          end else begin
            err_set = 1'b1;
          end
        end else begin
          // A different command mid-frame drops the partial frame.
          state_next = ST_IDLE;
          err_set    = 1'b1;
        end
`ifdef LOADER_FRAME_CHECK_EN
        if (halt_in) err_set = 1'b1;
`endif
      end

      ST_RUN: begin
        if (mode != MODE_RUN) state_next = ST_IDLE;
        else if (halt_in)     state_next = ST_DONE;
      end

      ST_DONE: begin
        if (mode != MODE_RUN) state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // State and output registers; run/done are decoded from the next state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    if (rst) begin
      state    <= ST_IDLE;
      imem_we  <= 1'b0;
      dmem_we  <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      run_en   <= 1'b0;
      done_out <= 1'b0;
      err_out  <= 1'b0;
    end else begin
      state    <= state_next;
      imem_we  <= imem_we_next;
      dmem_we  <= dmem_we_next;
      run_en   <= (state_next == ST_RUN);
      done_out <= (state_next == ST_DONE);
      if (commit) begin
        wr_addr <= frame[ADDR_LSB +: ADDR_W];
        wr_data <= frame[DATA_LSB +: DATA_W];
      end
      if (err_set) err_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_load_receiver.sv
// Self-checking bench for load_receiver: a frame table drives loads and
// queues expected writes; a monitor pops and compares every strobe.
module tb_load_receiver;

`ifdef LOADER_FRAME_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       mosi_in;
  logic [1:0] mode_in;
  logic       halt_in;
  logic       imem_we, dmem_we, run_en, done_out, err_out;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [14:0] bits;   // sent LSB first
    int          nbits;
    bit          wr;
    logic [3:0]  addr;
    logic [7:0]  data;
    bit          err;    // err_out expected after the frame
  } vec_t;

  typedef struct {
    bit         is_i;
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  localparam int NV = 8;
  vec_t tbl [NV];
  wr_t  sb [$];

  load_receiver dut (
    .clk      (clk),
    .rst      (rst),
    .mosi_in  (mosi_in),
    .mode_in  (mode_in),
    .halt_in  (halt_in),
    .imem_we  (imem_we),
    .dmem_we  (dmem_we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .run_en   (run_en),
    .done_out (done_out),
    .err_out  (err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Present inputs, let one rising edge sample them, return 1 time unit later.
  task automatic step(input logic [1:0] m, input logic b, input logic h);
    mode_in = m;
    mosi_in = b;
    halt_in = h;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step(2'b00, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic send_bits(input logic [1:0] m, input logic [14:0] bits, input int lo, input int hi);
    for (int k = lo; k < hi; k++) step(m, bits[k], 1'b0);
  endtask

  initial begin
    wr_t         e;
    logic [14:0] v;

    rst = 1'b1; mode_in = 2'b00; mosi_in = 1'b0; halt_in = 1'b0;

    //            mode   bits      n   wr    addr   data   err
    tbl[0] = '{2'b01, 15'h0A53, 13, 1'b1, 4'h3, 8'hA5, 1'b0};
    tbl[1] = '{2'b10, 15'h0F3F, 15, 1'b1, 4'hF, 8'h3C, 1'b0};  // 2 surplus lead samples
    tbl[2] = '{2'b10, 15'h0FF0, 13, 1'b1, 4'h0, 8'hFF, 1'b0};
    tbl[3] = '{2'b01, 15'h1FFE, 14, 1'b1, 4'hF, 8'hFF, 1'b0};  // 1 surplus lead sample
    tbl[4] = '{2'b01, 15'h17E9, 13, !CHK, 4'h9, 8'h7E, CHK};    // pad bit set
    tbl[5] = '{2'b01, 15'h01FF,  9, 1'b0, 4'h0, 8'h00, 1'b1};  // short frame
    tbl[6] = '{2'b10, 15'h0A53, 13, 1'b1, 4'h3, 8'hA5, 1'b1};  // err stays sticky
    tbl[7] = '{2'b01, 15'h0FFF, 12, 1'b0, 4'h0, 8'h00, 1'b1};  // one bit short

    // Monitor: every strobe must match the oldest queued expectation.
    fork
      forever begin
        @(negedge clk);
        if (imem_we || dmem_we) begin
          check("we_exclusive", {31'd0, imem_we & dmem_we}, 32'd0);
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: imem_we=%0b dmem_we=%0b addr=0x%0h data=0x%0h, required no strobe",
                     imem_we, dmem_we, wr_addr, wr_data);
          end else begin
            e = sb.pop_front();
            check("sb_imem_we", {31'd0, imem_we}, {31'd0, e.is_i});
            check("sb_dmem_we", {31'd0, dmem_we}, {31'd0, !e.is_i});
            check("sb_wr_addr", {28'd0, wr_addr}, {28'd0, e.addr});
            check("sb_wr_data", {24'd0, wr_data}, {24'd0, e.data});
          end
        end
      end
    join_none

    // Reset state.
    repeat (3) step(2'b00, 1'b0, 1'b0);
    check("rst_imem_we", {31'd0, imem_we}, 32'd0);
    check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    check("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_run_en",  {31'd0, run_en},  32'd0);
    check("rst_done",    {31'd0, done_out}, 32'd0);
    check("rst_err",     {31'd0, err_out}, 32'd0);
    rst = 1'b0;
    step(2'b00, 1'b0, 1'b0);

    // Table frames, back to back with one idle cycle between them.
    for (int i = 0; i < NV; i++) begin
      send_bits(tbl[i].mode, tbl[i].bits, 0, tbl[i].nbits);
      if (tbl[i].wr) sb.push_back('{tbl[i].mode == 2'b01, tbl[i].addr, tbl[i].data});
      step(2'b00, 1'b0, 1'b0);
      check($sformatf("v%0d_imem_we", i), {31'd0, imem_we}, {31'd0, tbl[i].wr && tbl[i].mode == 2'b01});
      check($sformatf("v%0d_dmem_we", i), {31'd0, dmem_we}, {31'd0, tbl[i].wr && tbl[i].mode == 2'b10});
      check($sformatf("v%0d_err", i),     {31'd0, err_out}, {31'd0, tbl[i].err});
    end

    // Mode switch mid-frame: error, no write; the new mode starts next cycle.
    reset_pulse();
    check("sw_err_cleared", {31'd0, err_out}, 32'd0);
    repeat (5) step(2'b01, 1'b1, 1'b0);
    v = 15'h079F;                      // bit 0 lands in the switch cycle, unsampled
    step(2'b10, v[0], 1'b0);
    check("sw_err", {31'd0, err_out}, 32'd1);
    check("sw_no_we", {30'd0, imem_we, dmem_we}, 32'd0);
    send_bits(2'b10, v, 1, 14);
    sb.push_back('{1'b0, 4'hF, 8'h3C});
    step(2'b00, 1'b0, 1'b0);
    check("sw_dmem_we", {31'd0, dmem_we}, 32'd1);

    // Reset mid-frame: partial frame discarded, fresh frame lands.
    reset_pulse();
    send_bits(2'b01, 15'h0A53, 0, 6);
    rst = 1'b1;
    step(2'b00, 1'b0, 1'b0);
    rst = 1'b0;
    check("rstmid_imem_we", {31'd0, imem_we}, 32'd0);
    check("rstmid_run_en", {31'd0, run_en}, 32'd0);
    send_bits(2'b01, 15'h0A53, 0, 13);
    sb.push_back('{1'b1, 4'h3, 8'hA5});
    step(2'b00, 1'b0, 1'b0);
    check("rstmid_fresh_we", {31'd0, imem_we}, 32'd1);
    check("rstmid_err", {31'd0, err_out}, 32'd0);

    // Run / halt sequence.
    step(2'b11, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      check($sformatf("run_en_c%0d", i), {31'd0, run_en}, 32'd1);
      check($sformatf("run_done_c%0d", i), {31'd0, done_out}, 32'd0);
      if (i < 20) step(2'b11, 1'b0, 1'b0);
    end
    step(2'b11, 1'b0, 1'b1);
    check("halt_run_en", {31'd0, run_en}, 32'd0);
    check("halt_done", {31'd0, done_out}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 1'b0, 1'b1);
      check($sformatf("done_hold%0d", i), {31'd0, done_out}, 32'd1);
    end
    step(2'b00, 1'b0, 1'b0);
    check("done_fall", {31'd0, done_out}, 32'd0);
    check("done_run_en", {31'd0, run_en}, 32'd0);

    // Run abort without halt.
    step(2'b11, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b0);
    check("abort_run_hi", {31'd0, run_en}, 32'd1);
    step(2'b00, 1'b0, 1'b0);
    check("abort_run_lo", {31'd0, run_en}, 32'd0);
    check("abort_done", {31'd0, done_out}, 32'd0);

    // Reset mid-run.
    repeat (3) step(2'b11, 1'b0, 1'b0);
    rst = 1'b1;
    step(2'b11, 1'b0, 1'b0);
    rst = 1'b0;
    check("rstrun_run_en", {31'd0, run_en}, 32'd0);
    step(2'b00, 1'b0, 1'b0);

    // halt_in while idle only matters with the frame checker built in.
    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b0);
    check("halt_idle_err", {31'd0, err_out}, {31'd0, CHK});

    step(2'b00, 1'b0, 1'b0);
    check("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
